bf_mem_wait: RTL and testbench

//  Parametrised single-port synchronous memory for the bf8b CPU.

---
 rtl/bf_mem_pkg.sv | 16 +
 rtl/bf_mem_array.sv | 28 ++
 rtl/bf_mem_wait.sv | 130 +++++++++++++
 tb/tb_bf_mem_wait.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_mem_pkg.sv
// Shared definitions for the bf8b wait-state memory: FSM encodings, latency bound,
// and the wait-counter width helper.
package bf_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned LATENCY_MAX = 15;

    // A latency of 0 or 1 still gets a 1-bit counter so the register never collapses.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/bf_mem_array.sv
// Single-port synchronous storage array, read-first: a write edge returns the old word.
// No reset; contents are undefined until written.
module bf_mem_array
    import bf_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bf_mem_wait.sv
// Parametrised single-port memory with req/ready handshake and configurable wait states.
// Define MEM_WRPROT_EN to make addresses 0..ROM_TOP read-only (writes flagged with err).
module bf_mem_wait
    import bf_mem_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       LATENCY = 0,
    parameter logic [ADDR_W-1:0] ROM_TOP = 'h1F
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned LAT      = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int unsigned CNT_W    = cnt_width(LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT == 0) ? 0 : LAT - 1);
`ifdef MEM_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    logic [1:0]        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_hold;

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_prot;
    logic              w_q_prot;
    logic              w_arr_we;
    logic [DATA_W-1:0] w_arr_rdata;
    logic [DATA_W-1:0] w_resp_data;

    assign w_accept     = i_req && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    assign w_enter_resp = (w_accept && (LAT == 0)) || ((r_state == ST_WAIT) && (r_cnt == '0));

    // With zero wait states the array must see the bus directly on the accept edge.
    assign w_sel_we    = w_accept ? i_we    : r_we;
    assign w_sel_addr  = w_accept ? i_addr  : r_addr;
    assign w_sel_wdata = w_accept ? i_wdata : r_wdata;

    assign w_sel_prot = WRPROT && (w_sel_addr <= ROM_TOP);
    assign w_q_prot   = WRPROT && (r_addr <= ROM_TOP);
    assign w_arr_we   = w_enter_resp && w_sel_we && !w_sel_prot;

    bf_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_addr  (w_sel_addr),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Array is read-first, so a committed write is reflected by forwarding the captured data.
    assign w_resp_data = (r_we && !w_q_prot) ? r_wdata : w_arr_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (LAT == 0) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (r_state == ST_RESP) begin
                r_rdata_hold <= w_resp_data;
            end
        end
    end

    assign o_ready = (r_state == ST_RESP);
    assign o_busy  = (r_state == ST_WAIT);
    assign o_err   = (r_state == ST_RESP) && r_we && w_q_prot;
    assign o_rdata = (r_state == ST_RESP) ? w_resp_data : r_rdata_hold;

endmodule

// File: tb/tb_bf_mem_wait.sv
// Self-checking bench: three instances (LATENCY 0, 1, 3) share one stimulus stream and are
// compared every cycle against a timing/memory model; honours MEM_WRPROT_EN if defined.
module tb_bf_mem_wait;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata [3];
    logic       ready [3];
    logic       busy  [3];
    logic       err   [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bf_mem_wait #(
            .DATA_W  (8),
            .ADDR_W  (8),
            .LATENCY (lat_of(g)),
            .ROM_TOP (8'h1F)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_req   (req),
            .i_we    (we),
            .i_addr  (addr),
            .i_wdata (wdata),
            .o_rdata (rdata[g]),
            .o_ready (ready[g]),
            .o_busy  (busy[g]),
            .o_err   (err[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit prot(input logic [7:0] a);
`ifdef MEM_WRPROT_EN
        return a <= 8'h1F;
`else
        return (a != a);
`endif
    endfunction

    // Inputs as seen by the DUT on each rising edge
    logic       s_rst = 1'b0;
    logic       s_req, s_we;
    logic [7:0] s_addr, s_wdata;
    always @(posedge clk) begin
        s_rst   <= rst_n;
        s_req   <= req;
        s_we    <= we;
        s_addr  <= addr;
        s_wdata <= wdata;
    end

    // Model: an access accepted at edge e completes (commits, responds) at edge e+L;
    // the next request can be taken at any edge after that.
    int         n = 0;
    bit         act   [3];
    int         acc_e [3];
    bit         p_we  [3];
    logic [7:0] p_addr[3];
    logic [7:0] p_wd  [3];
    logic [7:0] e_rdata [3];
    bit         e_known [3];
    logic [7:0] mem   [3][256];
    bit         known [3][256];

    always @(negedge clk) begin
        if (!s_rst) begin
            for (int d = 0; d < 3; d++) act[d] = 1'b0;
        end else begin
            n++;
            for (int d = 0; d < 3; d++) begin
                if (s_req && (!act[d] || n > acc_e[d] + lat_of(d))) begin
                    act[d] = 1'b1;
                    acc_e[d] = n;
                    p_we[d] = s_we;
                    p_addr[d] = s_addr;
                    p_wd[d] = s_wdata;
                end
                if (act[d] && n == acc_e[d] + lat_of(d)) begin
                    if (p_we[d] && !prot(p_addr[d])) begin
                        mem[d][p_addr[d]] = p_wd[d];
                        known[d][p_addr[d]] = 1'b1;
                    end
                    e_rdata[d] = mem[d][p_addr[d]];
                    e_known[d] = known[d][p_addr[d]];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            automatic bit rdy = act[d] && (n == acc_e[d] + lat_of(d));
            automatic bit bsy = act[d] && (n >= acc_e[d]) && (n < acc_e[d] + lat_of(d));
            chk($sformatf("ready[%0d]", d), 32'(ready[d]), 32'(rdy));
            chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(bsy));
            chk($sformatf("err[%0d]", d), 32'(err[d]), 32'(rdy && p_we[d] && prot(p_addr[d])));
            if (rdy && e_known[d]) chk($sformatf("rdata[%0d]", d), 32'(rdata[d]), 32'(e_rdata[d]));
        end
    end

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] wd);
        req = r;
        we = w;
        addr = a;
        wdata = wd;
    endtask

    // Issue one access and let every instance finish it
    task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] wd);
        drive(1'b1, w, a, wd);
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
    endtask

`ifdef MEM_WRPROT_EN
    localparam logic [7:0] B4 = 8'h30;
`else
    localparam logic [7:0] B4 = 8'h00;
`endif

    initial begin
        int found;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'h0);
            chk("rst_busy", 32'(busy[d]), 32'h0);
            chk("rst_err", 32'(err[d]), 32'h0);
            chk("rst_rdata", 32'(rdata[d]), 32'h0);
        end

        // Zero wait states: write then read back E1
        drive(1'b1, 1'b1, 8'hE1, 8'h0F);
        @(negedge clk);
        chk("l0_wr_ready", 32'(ready[0]), 32'h1);
        chk("l0_wr_rdata", 32'(rdata[0]), 32'h0F);
        drive(1'b1, 1'b0, 8'hE1, 8'h00);
        @(negedge clk);
        chk("l0_rd_ready", 32'(ready[0]), 32'h1);
        chk("l0_rd_rdata", 32'(rdata[0]), 32'h0F);
        req = 1'b0;
        repeat (6) @(negedge clk);

        // LATENCY=3: three busy cycles then ready; a second req while busy is ignored
        drive(1'b1, 1'b0, 8'hE1, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("l3_busy", 32'(busy[2]), 32'(k < 4));
            chk("l3_ready", 32'(ready[2]), 32'(k == 4));
            if (k == 4) begin
                chk("l3_rdata", 32'(rdata[2]), 32'h0F);
                req = 1'b0;
            end else begin
                addr = 8'h05;
            end
        end
        repeat (6) @(negedge clk);

        // LATENCY=1 back-to-back reads with req held high
        for (int i = 0; i < 4; i++) do_access(1'b1, B4 + 8'(i), 8'hA0 + 8'(i));
        drive(1'b1, 1'b0, B4, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready[1]), 32'(c % 2 == 0));
            if (c % 2 == 0) begin
                chk("b2b_rdata", 32'(rdata[1]), 32'(8'hA0 + 8'(c / 2 - 1)));
                addr = B4 + 8'(c / 2);
            end
        end
        req = 1'b0;
        repeat (6) @(negedge clk);

`ifdef MEM_WRPROT_EN
        drive(1'b1, 1'b1, 8'h10, 8'hAA);
        @(negedge clk);
        chk("prot_ready", 32'(ready[0]), 32'h1);
        chk("prot_err", 32'(err[0]), 32'h1);
        req = 1'b0;
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b1, 8'h20, 8'h5A);
        @(negedge clk);
        chk("unprot_err", 32'(err[0]), 32'h0);
        chk("unprot_rdata", 32'(rdata[0]), 32'h5A);
        req = 1'b0;
        repeat (6) @(negedge clk);
`endif

        // Reset during the wait of a write drops it
        do_access(1'b1, 8'h40, 8'h33);
        drive(1'b1, 1'b1, 8'h40, 8'h55);
        @(negedge clk);
        req = 1'b0;
        chk("abort_busy", 32'(busy[2]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready[2]), 32'h0);
        chk("abort_busy0", 32'(busy[2]), 32'h0);
        chk("abort_rdata", 32'(rdata[2]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h40, 8'h00);
        found = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (ready[2] === 1'b1) begin
                chk("abort_old_data", 32'(rdata[2]), 32'h33);
                found++;
            end
        end
        chk("abort_read_seen", 32'(found), 32'h1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                logic [7:0] a;
                case ($urandom_range(0, 2))
                    0:       a = 8'h10;
                    1:       a = 8'h20;
                    default: a = 8'hE0;
                endcase
                a = a + 8'($urandom_range(0, 3));
                drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a,
                      8'($urandom));
            end
        end
        req = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
